p2_window_ctrl: RTL and testbench

Streaming sequencer for the 3x3 weighted-average (P2) filter stage of the dehazing pipeline. It accepts a raster-order 8-bit pixel stream for one frame, holds two line buffers and a 3x3 shift window, and presents one complete nine-tap window per interior pixel to the filter. It runs a valid/ready handshake on both sides and pulses a frame-done strobe when the frame completes.

---
 rtl/p2_window_ctrl.sv | 157 +++++++++++++++
 tb/tb_p2_window_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/p2_window_ctrl.sv
// rtl/p2_window_ctrl.sv - 3x3 window sequencer with two line buffers for the P2 filter stage
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               arms one frame (only honoured in IDLE)
//   in_data/in_valid/in_ready     raster-order 8-bit pixel stream
//   win_data/win_valid/win_ready  nine-tap window, tap k at [8k-1:8k-8], row-major
//   win_row, win_col    centre coordinates of the presented window
//   busy                block is not IDLE
//   frame_done          one-cycle pulse after the last window handshakes
module p2_window_ctrl #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [71:0] win_data,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [11:0] win_row,
    output logic [11:0] win_col,
    output logic        busy,
    output logic        frame_done
);

    localparam int          AW           = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [24:0] TOTAL        = 25'(IMG_WIDTH * IMG_HEIGHT);
    localparam logic [11:0] LAST_COL     = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] WIN_LAST_ROW = 12'(IMG_HEIGHT - 2);
    localparam logic [11:0] WIN_LAST_COL = 12'(IMG_WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [11:0] col;
    logic [11:0] row;
    logic [24:0] pix_cnt;

    // line1 holds line R-1, line2 holds line R-2 relative to the incoming line R
    logic [7:0]  line1 [IMG_WIDTH];
    logic [7:0]  line2 [IMG_WIDTH];

    // Column vectors: [7:0] = row R-2, [15:8] = row R-1, [23:16] = row R.
    // col_l / col_m hold columns C-2 / C-1; the column for C is formed
    // directly from the RAM reads and in_data in the acceptance cycle.
    logic [23:0] col_l;
    logic [23:0] col_m;
    logic [23:0] col_new;

    logic [AW-1:0] addr;
    logic          accept;
    logic          emit;
    logic          last_hs;

    assign addr    = col[AW-1:0];
    assign accept  = in_valid && in_ready;
    assign col_new = {in_data, line1[addr], line2[addr]};
    // Gating on C>=2 also suppresses windows that would straddle a line wrap
    assign emit    = accept && (row >= 12'd2) && (col >= 12'd2);
    assign last_hs = win_valid && win_ready &&
                     (win_row == WIN_LAST_ROW) && (win_col == WIN_LAST_COL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                in_ready = (pix_cnt < TOTAL) && (!win_valid || win_ready);
                if (last_hs) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            pix_cnt   <= '0;
            col_l     <= '0;
            col_m     <= '0;
            win_valid <= 1'b0;
            win_data  <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                col     <= '0;
                row     <= '0;
                pix_cnt <= '0;
            end else if (accept) begin
                pix_cnt <= pix_cnt + 25'd1;
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + 12'd1;
                end else begin
                    col <= col + 12'd1;
                end
                col_l <= col_m;
                col_m <= col_new;
            end

            // A new window may replace the one being handed off in the same cycle
            if (emit) begin
                win_valid <= 1'b1;
                win_data  <= {col_new[23:16], col_m[23:16], col_l[23:16],
                              col_new[15:8],  col_m[15:8],  col_l[15:8],
                              col_new[7:0],   col_m[7:0],   col_l[7:0]};
                win_row   <= row - 12'd1;
                win_col   <= col - 12'd1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    // Line buffers are never cleared; the first two lines of a frame refill them
    always_ff @(posedge clk) begin
        if (accept) begin
            line2[addr] <= line1[addr];
            line1[addr] <= in_data;
        end
    end

endmodule

// File: tb/tb_p2_window_ctrl.sv
// tb/tb_p2_window_ctrl.sv - self-checking bench for p2_window_ctrl on 4x4, 5x3 and 8x8 frames
module tb_p2_window_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start      [3];
    logic [7:0]  in_data    [3];
    logic        in_valid   [3];
    logic        in_ready   [3];
    logic [71:0] win_data   [3];
    logic        win_valid  [3];
    logic        win_ready  [3];
    logic [11:0] win_row    [3];
    logic [11:0] win_col    [3];
    logic        busy       [3];
    logic        frame_done [3];

    always #5 clk = ~clk;

    int WI [3] = '{4, 5, 8};
    int HI [3] = '{4, 3, 8};

    p2_window_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_4x4 (
        .clk(clk), .rst(rst), .start(start[0]), .in_data(in_data[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .win_data(win_data[0]),
        .win_valid(win_valid[0]), .win_ready(win_ready[0]), .win_row(win_row[0]),
        .win_col(win_col[0]), .busy(busy[0]), .frame_done(frame_done[0]));

    p2_window_ctrl #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) u_5x3 (
        .clk(clk), .rst(rst), .start(start[1]), .in_data(in_data[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .win_data(win_data[1]),
        .win_valid(win_valid[1]), .win_ready(win_ready[1]), .win_row(win_row[1]),
        .win_col(win_col[1]), .busy(busy[1]), .frame_done(frame_done[1]));

    p2_window_ctrl #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) u_8x8 (
        .clk(clk), .rst(rst), .start(start[2]), .in_data(in_data[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .win_data(win_data[2]),
        .win_valid(win_valid[2]), .win_ready(win_ready[2]), .win_row(win_row[2]),
        .win_col(win_col[2]), .busy(busy[2]), .frame_done(frame_done[2]));

    typedef struct packed {
        logic [71:0] d;
        logic [11:0] r;
        logic [11:0] c;
    } win_t;

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         fd_cnt [3] = '{0, 0, 0};
    int         fd_cyc [3] = '{0, 0, 0};
    int         hs_cyc [3] = '{0, 0, 0};
    win_t       got   [$];
    win_t       exp_q [$];
    logic [7:0] img   [64];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake scoreboard, stall rule and frame_done bookkeeping
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (win_valid[i] === 1'b1 && win_ready[i] === 1'b1) begin
                got.push_back({win_data[i], win_row[i], win_col[i]});
                if (win_row[i] == 12'(HI[i] - 2) && win_col[i] == 12'(WI[i] - 2))
                    hs_cyc[i] = cyc;
            end
            if (win_valid[i] === 1'b1 && win_ready[i] === 1'b0)
                chk("stall_in_ready", 72'(in_ready[i]), 72'd0);
            if (frame_done[i] === 1'b1) begin
                fd_cnt[i]++;
                fd_cyc[i] = cyc;
            end
        end
    end

    task automatic check_reset(input int i);
        chk("rst_in_ready",   72'(in_ready[i]),   72'd0);
        chk("rst_win_valid",  72'(win_valid[i]),  72'd0);
        chk("rst_win_data",   win_data[i],        72'd0);
        chk("rst_win_row",    72'(win_row[i]),    72'd0);
        chk("rst_win_col",    72'(win_col[i]),    72'd0);
        chk("rst_busy",       72'(busy[i]),       72'd0);
        chk("rst_frame_done", 72'(frame_done[i]), 72'd0);
    endtask

    // Feed one frame into DUT i; start_at injects a start pulse mid-frame,
    // abort_at asserts rst once that many pixels have been accepted.
    task automatic run_frame(input int i, input int base, input bit rnd_img,
                             input bit rnd_rdy, input int start_at, input int abort_at);
        int   w, h, idx, guard, fd0;
        win_t e;
        w = WI[i];
        h = HI[i];
        for (int p = 0; p < w * h; p++)
            img[p] = rnd_img ? 8'($urandom) : 8'(base + 10 * (p / w) + p % w);
        exp_q.delete();
        got.delete();
        for (int r = 1; r <= h - 2; r++) begin
            for (int c = 1; c <= w - 2; c++) begin
                e.r = 12'(r);
                e.c = 12'(c);
                for (int k = 0; k < 9; k++)
                    e.d[8*k +: 8] = img[(r + k / 3 - 1) * w + c + k % 3 - 1];
                exp_q.push_back(e);
            end
        end
        fd0 = fd_cnt[i];

        @(posedge clk); #1;
        in_valid[i]  = 1'b1;
        in_data[i]   = 8'hEE;
        win_ready[i] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            start[i] = (n == 2);
            @(negedge clk);
            chk("idle_in_ready", 72'(in_ready[i]), 72'd0);
            @(posedge clk); #1;
        end
        start[i] = 1'b0;

        idx   = 0;
        guard = 0;
        while (idx < w * h && guard < 4000 && idx != abort_at) begin
            in_valid[i]  = 1'b1;
            in_data[i]   = img[idx];
            win_ready[i] = rnd_rdy ? 1'($urandom) : 1'b1;
            start[i]     = (idx == start_at);
            @(negedge clk);
            if (in_ready[i]) idx++;
            @(posedge clk); #1;
            guard++;
        end
        start[i]    = 1'b0;
        in_valid[i] = 1'b0;

        if (abort_at >= 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check_reset(i);
            repeat (6) @(posedge clk);
            #1;
            chk("abort_frame_done", 72'(fd_cnt[i] - fd0), 72'd0);
            chk("abort_busy", 72'(busy[i]), 72'd0);
            return;
        end

        while (fd_cnt[i] == fd0 && guard < 4000) begin
            win_ready[i] = rnd_rdy ? 1'($urandom) : 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        chk("timeout", 72'(guard < 4000), 72'd1);
        win_ready[i] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("frame_done_pulses", 72'(fd_cnt[i] - fd0), 72'd1);
        chk("frame_done_timing", 72'(fd_cyc[i] - hs_cyc[i]), 72'd1);
        chk("busy_after", 72'(busy[i]), 72'd0);
        chk("window_count", 72'(got.size()), 72'(exp_q.size()));
        for (int n = 0; n < got.size() && n < exp_q.size(); n++) begin
            chk("win_data", got[n].d, exp_q[n].d);
            chk("win_row",  72'(got[n].r), 72'(exp_q[n].r));
            chk("win_col",  72'(got[n].c), 72'(exp_q[n].c));
        end
    endtask

    initial begin
        int          filt;
        logic [71:0] w11;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i]     = 1'b0;
            in_data[i]   = 8'd0;
            in_valid[i]  = 1'b0;
            win_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset(i);

        // 4x4 ramp p(r,c)=10r+c, plus explicit taps of window (1,1)
        run_frame(0, 0, 1'b0, 1'b0, -1, -1);
        w11 = {8'd22, 8'd21, 8'd20, 8'd12, 8'd11, 8'd10, 8'd2, 8'd1, 8'd0};
        chk("w11_present", 72'(got.size() > 0), 72'd1);
        if (got.size() > 0) begin
            chk("w11_taps", got[0].d, w11);
            filt = (1 * got[0].d[7:0]   + 2 * got[0].d[15:8]  + 1 * got[0].d[23:16] +
                    2 * got[0].d[31:24] + 4 * got[0].d[39:32] + 2 * got[0].d[47:40] +
                    1 * got[0].d[55:48] + 2 * got[0].d[63:56] + 1 * got[0].d[71:64]) / 16;
            chk("w11_filter", 72'(filt), 72'd11);
        end

        // 5x3: three windows on row 1, none across the line wrap
        run_frame(1, 0, 1'b0, 1'b0, -1, -1);

        // 8x8 random pixels with random backpressure
        run_frame(2, 0, 1'b1, 1'b1, -1, -1);

        // start pulsed mid-frame must be ignored
        run_frame(2, 0, 1'b1, 1'b1, 20, -1);

        // rst after 10 pixels, then a clean full frame
        run_frame(0, 0, 1'b1, 1'b0, -1, 10);
        run_frame(0, 0, 1'b1, 1'b1, -1, -1);

        // back-to-back frames with different data
        run_frame(0, 100, 1'b0, 1'b0, -1, -1);
        run_frame(0, 0, 1'b1, 1'b1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
